imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side counterpart to the SEQ fetch stage's instruction-memory read path.
- Receives a framed byte stream over a valid/ready handshake and writes the payload bytes into instruction memory through a write port.
- Checks an XOR checksum over the payload.
- Asserts cpu_run only after a clean load, so the SEQ core (PC starting at 0) fetches a fully written program.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width; capacity = 2^ADDR_W bytes.
- LEN_W, 16, width of the frame length field; must be at least ADDR_W+1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new load from IDLE, DONE or ERR.
- in_valid  in  1  source presents a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_we  out  1  one-cycle instruction-memory write strobe.
- mem_addr  out  ADDR_W  write byte address.
- mem_wdata  out  8  write byte.
- cpu_run  out  1  held high while in DONE; releases the core.
- load_err  out  1  held high while in ERR.
- bytes_loaded  out  LEN_W  count of payload bytes written in the current or last load.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, load_err=0, bytes_loaded=0; internal length, index and checksum cleared. Reset mid-load abandons the frame; bytes already written to memory are not undone.
- Transfer: occurs on a rising edge with in_valid & in_ready. in_ready is a registered function of state: 1 in LEN0, LEN1, LOAD, CSUM; 0 in IDLE, DONE, ERR.
- Frame format: LEN low byte, LEN high byte (little-endian, LEN_W=16), LEN payload bytes, one checksum byte equal to the XOR of all payload bytes.
- IDLE: start -> LEN0; clear bytes_loaded, index and checksum.
- LEN0: transfer -> latch low byte -> LEN1.
- LEN1: transfer -> latch high byte, then:
  - LEN > 2^ADDR_W -> ERR, with no memory write.
  - LEN == 0 -> CSUM.
  - otherwise -> LOAD.
- LOAD: each transfer of byte b:
  - next cycle mem_we=1, mem_addr=index, mem_wdata=b; one-cycle latency, single-cycle pulse;
  - checksum ^= b; index += 1; bytes_loaded += 1;
  - after the LEN-th transfer -> CSUM;
  - back-to-back transfers yield back-to-back write strobes at consecutive addresses.
- CSUM: transfer of c:
  - c == checksum -> DONE.
  - c != checksum -> ERR.
  - Checksum is 0 for LEN=0.
- DONE: cpu_run=1 from the cycle after the checksum transfer; remains high until start or reset.
- ERR: load_err=1; cpu_run=0; remains until start or reset.
- start in DONE or ERR: -> LEN0 on the next edge; cpu_run/load_err drop in the same cycle in_ready rises; counters cleared.
- start in LEN0, LEN1, LOAD or CSUM: ignored.
- in_valid while in_ready=0: ignored; no state change.
- Address never wraps: LEN=2^ADDR_W writes addresses 0..2^ADDR_W-1 exactly; larger LEN is rejected in LEN1.
- mem_addr and mem_wdata hold their last value when mem_we=0.

Test Plan:
- Reset, start, then stream 03 00 30 F4 00 with in_valid always high -> mem_we pulses on three consecutive cycles at addr 0,1,2 with data 30,F4,00; checksum byte C4 then gives cpu_run=1 and bytes_loaded=3.
- Same frame with the checksum byte replaced by C5 -> load_err=1, cpu_run=0; three writes still observed; a subsequent start clears load_err and raises in_ready.
- Frame 00 04 (LEN=1024), ADDR_W=10, 1024 bytes of pattern i[7:0] and correct checksum 00 -> last write at addr 1023 data FF, then cpu_run=1; a frame 01 04 (LEN=1025) -> ERR immediately after the length bytes, with zero writes.
- LEN=0 frame 00 00 00 -> DONE with no mem_we; frame 00 00 01 -> ERR.
- Bubbled in_valid (high every third cycle) on the 3-byte frame -> writes occur only one cycle after each transfer and addresses stay consecutive; start pulsed during LOAD has no effect.
- rst_n pulled low after the second payload byte -> all outputs return to reset values asynchronously; a new start plus full frame loads correctly from addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (LEN lo, LEN hi, payload, XOR
// checksum) and writes the payload into instruction memory from address 0.
// cpu_run is raised only once a frame has been fully written and its
// checksum has matched, so the core never fetches a partially loaded image.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [LEN_W-1:0]  bytes_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_LOAD = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  // Largest legal frame: exactly fills the memory, so addresses never wrap.
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_CAP = LEN_ONE << ADDR_W;
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

  // Running XOR checksum update over payload bytes.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    csum_update = acc ^ b;
  endfunction

  // Ready is asserted exactly in the states that consume stream bytes.
  function automatic logic accepts_bytes(input state_t st);
    case (st)
      ST_LEN0, ST_LEN1, ST_LOAD, ST_CSUM: accepts_bytes = 1'b1;
      default:                            accepts_bytes = 1'b0;
    endcase
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;

  logic               in_ready_r;
  logic               mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [7:0]         mem_wdata_r;
  logic               cpu_run_r;
  logic               load_err_r;
  logic [LEN_W-1:0]   bytes_loaded_r;
  logic [7:0]         len_lo_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   index_r;
  logic [7:0]         csum_r;

  logic               in_ready_nxt_s;
  logic               mem_we_nxt_s;
  logic [ADDR_W-1:0]  mem_addr_nxt_s;
  logic [7:0]         mem_wdata_nxt_s;
  logic               cpu_run_nxt_s;
  logic               load_err_nxt_s;
  logic [LEN_W-1:0]   bytes_loaded_nxt_s;
  logic [7:0]         len_lo_nxt_s;
  logic [LEN_W-1:0]   len_nxt_s;
  logic [LEN_W-1:0]   index_nxt_s;
  logic [7:0]         csum_nxt_s;

  logic               fire_s;
  logic [LEN_W-1:0]   len_rx_s;
  logic [LEN_W-1:0]   index_inc_s;
  logic               last_byte_s;

  // A byte moves only when the source offers it and we advertised ready.
  assign fire_s      = in_valid & in_ready_r;
  // Full length as seen while the high byte is on the bus.
  assign len_rx_s    = LEN_W'({in_data, len_lo_r});
  assign index_inc_s = index_r + LEN_ONE;
  assign last_byte_s = (index_inc_s == len_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: frame parsing, length screening and checksum verdict.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_LEN0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LEN0: begin
        if (fire_s) begin
          state_nxt_s = ST_LEN1;
        end else begin
          state_nxt_s = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (!fire_s) begin
          state_nxt_s = ST_LEN1;
        end else if (len_rx_s > LEN_CAP) begin
          state_nxt_s = ST_ERR;
        end else if (len_rx_s == LEN_ZERO) begin
          state_nxt_s = ST_CSUM;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (fire_s && last_byte_s) begin
          state_nxt_s = ST_CSUM;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_CSUM: begin
        if (!fire_s) begin
          state_nxt_s = ST_CSUM;
        end else if (in_data == csum_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ERR;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_LEN0;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_ERR: begin
        if (start) begin
          state_nxt_s = ST_LEN0;
        end else begin
          state_nxt_s = ST_ERR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output/datapath decode: next values for every registered output and counter.
  always_comb begin
    in_ready_nxt_s     = accepts_bytes(state_nxt_s);
    cpu_run_nxt_s      = (state_nxt_s == ST_DONE);
    load_err_nxt_s     = (state_nxt_s == ST_ERR);
    mem_we_nxt_s       = 1'b0;
    mem_addr_nxt_s     = mem_addr_r;
    mem_wdata_nxt_s    = mem_wdata_r;
    bytes_loaded_nxt_s = bytes_loaded_r;
    len_lo_nxt_s       = len_lo_r;
    len_nxt_s          = len_r;
    index_nxt_s        = index_r;
    csum_nxt_s         = csum_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          bytes_loaded_nxt_s = LEN_ZERO;
          index_nxt_s        = LEN_ZERO;
          csum_nxt_s         = 8'h00;
        end else begin
          bytes_loaded_nxt_s = bytes_loaded_r;
        end
      end
      ST_LEN0: begin
        if (fire_s) begin
          len_lo_nxt_s = in_data;
        end else begin
          len_lo_nxt_s = len_lo_r;
        end
      end
      ST_LEN1: begin
        if (fire_s) begin
          len_nxt_s = len_rx_s;
        end else begin
          len_nxt_s = len_r;
        end
      end
      ST_LOAD: begin
        if (fire_s) begin
          mem_we_nxt_s       = 1'b1;
          mem_addr_nxt_s     = index_r[ADDR_W-1:0];
          mem_wdata_nxt_s    = in_data;
          csum_nxt_s         = csum_update(csum_r, in_data);
          index_nxt_s        = index_inc_s;
          bytes_loaded_nxt_s = bytes_loaded_r + LEN_ONE;
        end else begin
          mem_we_nxt_s = 1'b0;
        end
      end
      ST_CSUM: begin
        csum_nxt_s = csum_r;
      end
      default: begin
        mem_we_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs and frame bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r     <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= {ADDR_W{1'b0}};
      mem_wdata_r    <= 8'h00;
      cpu_run_r      <= 1'b0;
      load_err_r     <= 1'b0;
      bytes_loaded_r <= LEN_ZERO;
      len_lo_r       <= 8'h00;
      len_r          <= LEN_ZERO;
      index_r        <= LEN_ZERO;
      csum_r         <= 8'h00;
    end else begin
      in_ready_r     <= in_ready_nxt_s;
      mem_we_r       <= mem_we_nxt_s;
      mem_addr_r     <= mem_addr_nxt_s;
      mem_wdata_r    <= mem_wdata_nxt_s;
      cpu_run_r      <= cpu_run_nxt_s;
      load_err_r     <= load_err_nxt_s;
      bytes_loaded_r <= bytes_loaded_nxt_s;
      len_lo_r       <= len_lo_nxt_s;
      len_r          <= len_nxt_s;
      index_r        <= index_nxt_s;
      csum_r         <= csum_nxt_s;
    end
  end

  assign in_ready     = in_ready_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign cpu_run      = cpu_run_r;
  assign load_err     = load_err_r;
  assign bytes_loaded = bytes_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: drives framed byte streams with configurable
// valid bubbles; a monitor pops expected memory writes from a scoreboard queue.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 16;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_run;
  logic              load_err;
  logic [LEN_W-1:0]  bytes_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_run(cpu_run),
    .load_err(load_err), .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  int   vectors     = 0;
  int   miscompares = 0;
  wr_t  model_q[$];   // writes the reference model predicts for this frame
  wr_t  exp_q[$];     // writes due one cycle after an observed transfer
  logic [7:0] payload[$];
  int   bubble_mode = 0;  // 0: valid always, 1: every third cycle, 2: random gaps
  int   start_mid   = 0;  // pulse start before the second payload byte

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest pending expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1) begin
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_we", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
        end
      end else if (exp_q.size() != 0) begin
        check("missing_we", 32'd0, 32'd1);
        exp_q.delete();
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Begin a load and check the loader is accepting with status cleared.
  task automatic start_load();
    pulse_start();
    check("start_in_ready", 32'(in_ready), 32'd1);
    check("start_cpu_run", 32'(cpu_run), 32'd0);
    check("start_load_err", 32'(load_err), 32'd0);
    check("start_bytes", 32'(bytes_loaded), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_payload);
    int   gap;
    bit   ok;
    logic rdy;
    case (bubble_mode)
      1: gap = 2;
      2: gap = $urandom_range(0, 2);
      default: gap = 0;
    endcase
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy === 1'b1) begin
        ok = 1'b1;
        if (is_payload && model_q.size() > 0) exp_q.push_back(model_q.pop_front());
      end
      @(negedge clk);
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  // Reference model: a frame loads payload[i] at address i when LEN fits;
  // success requires the checksum byte to equal the XOR of the payload.
  task automatic send_frame(input int len, input logic [7:0] csum);
    logic [7:0] x;
    bit         exp_done;
    int         exp_bytes;
    wr_t        w;
    x = 8'h00;
    model_q.delete();
    if (len > CAP) begin
      exp_done  = 1'b0;
      exp_bytes = 0;
    end else begin
      for (int i = 0; i < len; i++) begin
        x = x ^ payload[i];
        w.addr = i[ADDR_W-1:0];
        w.data = payload[i];
        model_q.push_back(w);
      end
      exp_done  = (csum == x);
      exp_bytes = len;
    end
    send_byte(len[7:0], 1'b0);
    send_byte(len[15:8], 1'b0);
    if (len <= CAP) begin
      for (int i = 0; i < len; i++) begin
        if (start_mid != 0 && i == 1) pulse_start();
        send_byte(payload[i], 1'b1);
      end
      send_byte(csum, 1'b0);
    end
    check("end_cpu_run", 32'(cpu_run), 32'(exp_done));
    check("end_load_err", 32'(load_err), 32'(!exp_done));
    check("end_bytes", 32'(bytes_loaded), 32'(exp_bytes));
    check("end_in_ready", 32'(in_ready), 32'd0);
    check("end_writes_drained", 32'(exp_q.size() + model_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    check({tag, "_load_err"}, 32'(load_err), 32'd0);
    check({tag, "_bytes"}, 32'(bytes_loaded), 32'd0);
  endtask

  task automatic set_small_payload();
    payload.delete();
    payload.push_back(8'h30);
    payload.push_back(8'hF4);
    payload.push_back(8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    logic [7:0] x;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 3-byte frame, valid held high, good checksum.
    start_load();
    set_small_payload();
    send_frame(3, 8'hC4);

    // Valid while not ready is ignored: DONE persists, no writes.
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("idle_valid_cpu_run", 32'(cpu_run), 32'd1);
    check("idle_valid_bytes", 32'(bytes_loaded), 32'd3);

    // Bad checksum -> ERR, writes still happen; start clears the error.
    start_load();
    send_frame(3, 8'hC5);
    start_load();

    // Full-capacity frame.
    payload.delete();
    for (int i = 0; i < CAP; i++) payload.push_back(i[7:0]);
    send_frame(CAP, 8'h00);

    // Oversized frame rejected straight after the length bytes.
    start_load();
    payload.delete();
    send_frame(CAP + 1, 8'h00);

    // Empty frames.
    start_load();
    send_frame(0, 8'h00);
    start_load();
    send_frame(0, 8'h01);

    // Bubbled valid plus an ignored start during LOAD.
    bubble_mode = 1;
    start_mid   = 1;
    start_load();
    set_small_payload();
    send_frame(3, 8'hC4);
    bubble_mode = 0;
    start_mid   = 0;

    // Asynchronous reset mid-payload, then a clean reload.
    start_load();
    set_small_payload();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    model_q.delete();
    model_q.push_back('{addr: 10'd0, data: 8'h30});
    model_q.push_back('{addr: 10'd1, data: 8'hF4});
    send_byte(8'h30, 1'b1);
    send_byte(8'hF4, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_q.delete();
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_load();
    send_frame(3, 8'hC4);

    // Randomized frames with random bubbles and occasional bad checksums.
    bubble_mode = 2;
    for (int f = 0; f < 20; f++) begin
      start_load();
      payload.delete();
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(CAP + 1, 4000);
        send_frame(len, 8'h00);
      end else begin
        len = $urandom_range(0, 40);
        x = 8'h00;
        for (int i = 0; i < len; i++) begin
          payload.push_back(8'($urandom_range(0, 255)));
          x = x ^ payload[i];
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        send_frame(len, x);
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
